// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared default widths/thresholds and parameter sanity helper
//               for the synchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   localparam int c_DATA_W    = 16;
   localparam int c_ADDR_W    = 4;
   localparam int c_AF_THRESH = 12;
   localparam int c_AE_THRESH = 2;

   // Thresholds must leave a gap between almost_empty and almost_full and fit the depth.
   function automatic bit thresh_ok(input int ae, input int af, input int depth);
      return (ae < af) && (af <= depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_dpram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_dpram
// Description : Simple dual-port RAM, one write port and one registered read
//               port. Only the read register is reset; the array is not.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_dpram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int c_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [c_DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (re) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_sync_fifo
// Description : Parameterised single-clock FIFO with registered read data,
//               fill-level flags, sticky over/underflow and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W    = c_DATA_W,
   parameter int ADDR_W    = c_ADDR_W,
   parameter int AF_THRESH = c_AF_THRESH,
   parameter int AE_THRESH = c_AE_THRESH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow,
   input  logic              err_clr
);

   localparam int            c_DEPTH_I = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(c_DEPTH_I);
   localparam logic [ADDR_W:0] c_AF    = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] c_AE    = (ADDR_W+1)'(AE_THRESH);

   if (!thresh_ok(AE_THRESH, AF_THRESH, c_DEPTH_I)) begin : g_bad_thresh
      $error("param_sync_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_data_valid;
   logic              r_overflow;
   logic              r_underflow;
   logic              w_full;
   logic              w_empty;
   logic              w_wa;
   logic              w_ra;

   assign w_full  = (r_count == c_DEPTH);
   assign w_empty = (r_count == '0);

   // Reset and flush both suppress any transfer in their cycle.
   assign w_wa = wr_en && !w_full  && !flush && !rst;
   assign w_ra = rd_en && !w_empty && !flush && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_data_valid <= 1'b0;
      end else if (flush) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_data_valid <= w_ra;
         if (w_wa) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_ra) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         case ({w_wa, w_ra})
            2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A new error event takes precedence over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (!flush) begin
         if (wr_en && w_full) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end else if (err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   fifo_dpram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (w_wa),
      .waddr (r_wr_ptr),
      .wdata (data_in),
      .re    (w_ra),
      .raddr (r_rd_ptr),
      .rdata (data_out)
   );

   assign data_valid   = r_data_valid;
   assign count        = r_count;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= c_AF);
   assign almost_empty = (r_count <= c_AE);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_sync_fifo
// Description : Directed self-checking bench for param_sync_fifo, default and
//               wide/deep parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sync_fifo;

   logic        clk = 1'b0;
   logic        rst, flush, err_clr;
   logic        wr_en, rd_en;
   logic [15:0] data_in, data_out;
   logic        data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]  count;

   logic        b_wr_en, b_rd_en;
   logic [31:0] b_data_in, b_data_out;
   logic        b_data_valid, b_full, b_empty, b_af, b_ae, b_ov, b_un;
   logic [6:0]  b_count;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   param_sync_fifo dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(data_out), .data_valid(data_valid), .count(count),
      .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
   );

   param_sync_fifo #(.DATA_W(32), .ADDR_W(6), .AF_THRESH(60), .AE_THRESH(4)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(b_wr_en), .data_in(b_data_in),
      .rd_en(b_rd_en), .data_out(b_data_out), .data_valid(b_data_valid), .count(b_count),
      .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
      .overflow(b_ov), .underflow(b_un), .err_clr(err_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".count"},  32'(count), 32'd0);
      check({tag, ".dout"},   32'(data_out), 32'h0);
      check({tag, ".dv"},     32'(data_valid), 32'd0);
      check({tag, ".ov"},     32'(overflow), 32'd0);
      check({tag, ".un"},     32'(underflow), 32'd0);
      check({tag, ".empty"},  32'(empty), 32'd1);
      check({tag, ".ae"},     32'(almost_empty), 32'd1);
      check({tag, ".full"},   32'(full), 32'd0);
      check({tag, ".af"},     32'(almost_full), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; err_clr = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      b_wr_en = 1'b0; b_rd_en = 1'b0; b_data_in = '0;
      step(); step();
      rst = 1'b0;
      check_reset("rst0");

      // Fill to full with 0x0001..0x0010
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1; data_in = 16'(i);
         step();
         check("fill.count", 32'(count), 32'(i));
         check("fill.af", 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
      end
      check("fill.full", 32'(full), 32'd1);
      data_in = 16'hBEEF;
      step();
      wr_en = 1'b0;
      check("ovf.flag", 32'(overflow), 32'd1);
      check("ovf.count", 32'(count), 32'd16);

      // Drain in order, then one extra read
      for (int i = 1; i <= 16; i++) begin
         rd_en = 1'b1;
         step();
         check("drain.dv", 32'(data_valid), 32'd1);
         check("drain.data", 32'(data_out), 32'(i));
      end
      check("drain.empty", 32'(empty), 32'd1);
      step();
      rd_en = 1'b0;
      check("unf.flag", 32'(underflow), 32'd1);
      check("unf.dv", 32'(data_valid), 32'd0);
      check("unf.dout", 32'(data_out), 32'h10);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("clr.ov", 32'(overflow), 32'd0);
      check("clr.un", 32'(underflow), 32'd0);

      // Fill to 5 then stream 40 cycles with simultaneous read/write
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; data_in = 16'(16'h100 + i);
         step();
      end
      rd_en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         data_in = 16'(16'h105 + k);
         step();
         check("stream.count", 32'(count), 32'd5);
         check("stream.data", 32'(data_out), 32'(16'h100 + k));
      end
      wr_en = 1'b0;
      for (int k = 40; k < 45; k++) begin
         step();
         check("tail.data", 32'(data_out), 32'(16'h100 + k));
      end
      rd_en = 1'b0;
      check("tail.empty", 32'(empty), 32'd1);

      // Simultaneous request while empty
      wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0055;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      check("emboth.count", 32'(count), 32'd1);
      check("emboth.un", 32'(underflow), 32'd1);
      check("emboth.dv", 32'(data_valid), 32'd0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("emboth.clr", 32'(underflow), 32'd0);

      // Simultaneous request while full
      for (int i = 0; i < 15; i++) begin
         wr_en = 1'b1; data_in = 16'(16'h60 + i);
         step();
      end
      check("fl.full", 32'(full), 32'd1);
      rd_en = 1'b1; data_in = 16'h0077;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      check("flboth.count", 32'(count), 32'd15);
      check("flboth.ov", 32'(overflow), 32'd1);
      check("flboth.data", 32'(data_out), 32'h55);
      wr_en = 1'b1; data_in = 16'h006F;
      step();
      check("refill.count", 32'(count), 32'd16);
      // overflow set and err_clr in the same cycle: set must win
      err_clr = 1'b1;
      step();
      wr_en = 1'b0;
      check("setwin.ov", 32'(overflow), 32'd1);
      step();
      err_clr = 1'b0;
      check("clr2.ov", 32'(overflow), 32'd0);

      // Flush while full, then refill to 9 and flush with a write pending
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush1.count", 32'(count), 32'd0);
      check("flush1.dout", 32'(data_out), 32'h55);
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; data_in = 16'(16'h200 + i);
         step();
      end
      check("fill9.count", 32'(count), 32'd9);
      flush = 1'b1; data_in = 16'h0999;
      step();
      flush = 1'b0; wr_en = 1'b0;
      check("flush2.count", 32'(count), 32'd0);
      check("flush2.empty", 32'(empty), 32'd1);
      check("flush2.dout", 32'(data_out), 32'h55);
      check("flush2.dv", 32'(data_valid), 32'd0);
      rd_en = 1'b1;
      step();
      check("flush3.un", 32'(underflow), 32'd1);
      flush = 1'b1; err_clr = 1'b1;
      step();
      flush = 1'b0; err_clr = 1'b0; rd_en = 1'b0;
      check("flush3.hold", 32'(underflow), 32'd1);
      wr_en = 1'b1; data_in = 16'h0ABC;
      step();
      wr_en = 1'b0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("postflush.data", 32'(data_out), 32'hABC);
      check("postflush.dv", 32'(data_valid), 32'd1);

      // Reset mid-operation at count 9
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; data_in = 16'(16'h300 + i);
         step();
      end
      check("pre_rst.count", 32'(count), 32'd9);
      rst = 1'b1; rd_en = 1'b1;
      step();
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      check_reset("rst_mid");

      // Wide/deep parameter set
      for (int i = 1; i <= 64; i++) begin
         b_wr_en = 1'b1; b_data_in = 32'hA000_0000 + 32'(i);
         step();
         if (i == 4)  check("b.ae4", 32'(b_ae), 32'd1);
         if (i == 5)  check("b.ae5", 32'(b_ae), 32'd0);
         if (i == 59) check("b.af59", 32'(b_af), 32'd0);
         if (i == 60) check("b.af60", 32'(b_af), 32'd1);
         if (i == 63) check("b.full63", 32'(b_full), 32'd0);
      end
      b_wr_en = 1'b0;
      check("b.full64", 32'(b_full), 32'd1);
      check("b.count64", 32'(b_count), 32'd64);
      b_rd_en = 1'b1;
      step();
      check("b.data1", b_data_out, 32'hA000_0001);
      check("b.dv", 32'(b_data_valid), 32'd1);
      for (int i = 0; i < 58; i++) step();
      check("b.count5", 32'(b_count), 32'd5);
      check("b.ae_at5", 32'(b_ae), 32'd0);
      step();
      b_rd_en = 1'b0;
      check("b.ae_at4", 32'(b_ae), 32'd1);
      check("b.data60", b_data_out, 32'hA000_003C);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
